prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the single-cycle processor's instruction memory. It accepts a framed byte stream: 16-bit word count, big-endian instruction words, XOR checksum. It writes each assembled word into the instruction memory write port. It holds the processor in reset until a frame is loaded and its checksum has been verified.

## Interface
- `MAX_WORDS`, 256: instruction memory depth in words; the word address is 8 bits.
- `clk` in 1: single clock, shared with the processor and memories.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle. A transfer occurs when `in_valid & in_ready`.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out 8: word address, `0..MAX_WORDS-1`.
- `imem_wdata` out 32: instruction word.
- `cpu_run` out 1: 1 releases the processor. The processor reset is driven as `rst & cpu_run`.
- `busy` out 1: a load is in progress.
- `err` out 1: the last load failed, either on length or on checksum.

## Operation
- States:
  - `IDLE`: on `start`, go to `LEN_HI`; clear `err` and `cpu_run`.
  - `LEN_HI`: on transfer, `len[15:8]` = byte; go to `LEN_LO`.
  - `LEN_LO`: on transfer, `len[7:0]` = byte.
    - If `len > MAX_WORDS`, go to `ERR`.
    - Else if `len == 0`, go to `CSUM`.
    - Else go to `DATA`.
  - `DATA`: bytes pack into a word, MSB first: byte 0 → bits 31:24, byte 3 → bits 7:0.
    - On the 4th byte, write the word at address `wcnt`, then increment `wcnt`.
    - After word `len-1`, go to `CSUM`.
  - `CSUM`: on transfer, if byte equals `xsum`, go to `DONE`, else go to `ERR`.
  - `DONE`: `cpu_run` = 1. `start` returns to `LEN_HI` and drops `cpu_run`.
  - `ERR`: `err` = 1, `cpu_run` = 0. `start` returns to `LEN_HI`.
- `xsum` is the running XOR of payload bytes only; the length bytes are excluded. It is cleared on `start`.
- `in_ready` is 1 exactly in `LEN_HI`, `LEN_LO`, `DATA` and `CSUM`.
- `busy` is 1 in the same four states.
- `start` while `busy` is ignored.
- `in_valid` outside the `busy` states is ignored, and bytes are not consumed.
- Stalls: `in_valid = 0` for any number of cycles holds all state. There is no timeout.
- Memory words beyond `len` are left untouched.

## Timing
- Reset, asynchronous on `rst = 0`: state `IDLE`; `in_ready`, `imem_we`, `busy`, `err`, `cpu_run` = 0; `imem_addr`, `imem_wdata` = 0; counters and `xsum` = 0.
- `start` sampled in cycle N puts the FSM in `LEN_HI` at N+1, with `in_ready` = 1 in N+1.
- One byte is accepted per cycle maximum; a full-rate frame takes `2 + 4*len + 1` transfer cycles.
- `imem_we` is registered. It is a single-cycle pulse in the cycle after the 4th-byte transfer, with `imem_addr` and `imem_wdata` stable that cycle.
- The word write and the next byte's acceptance may overlap.
- `cpu_run` rises in the cycle after the checksum transfer.
- The processor executes its first fetch from address 0 on the edge after `rst & cpu_run` goes high.
- `err` rises in the cycle after the failing transfer: either `LEN_LO` with an over-length count, or `CSUM` with a mismatch.
- Reset mid-load: everything aborts immediately and `cpu_run` = 0. Partially written memory is not scrubbed.

## Structure
- Shared package `loader_pkg`: state enum (`IDLE`, `LEN_HI`, `LEN_LO`, `DATA`, `CSUM`, `DONE`, `ERR`), `MAX_WORDS`, and the address width localparam (8).
- One sub-module, `word_packer`:
  - Contains a 2-bit byte counter and a 32-bit shift register.
  - Outputs `word_valid` together with the word.
  - Takes a `clear` input driven on `start`.
- The top level holds the FSM, the `wcnt`/`len` counters, the `xsum` register and the output registers.

## Test plan
- `len` = 2, words `0x20010005`, `0x8C220000`, correct checksum → two `imem_we` pulses: address 0 ← `0x20010005`, address 1 ← `0x8C220000`. `cpu_run` = 1 and `err` = 0.
- Same frame with checksum XOR `0x01` → both words written, `err` = 1, `cpu_run` stays 0.
- `len` = `0x0101` (257) → `err` = 1 after `LEN_LO`, no `imem_we`, `in_ready` = 0.
- `len` = 0, checksum `0x00` → `DONE`, `cpu_run` = 1, no writes.
- `len` = 256 with random `in_valid` gaps → 256 writes, last at address `0xFF`. Every address written exactly once and no wrap to 0; `cpu_run` = 1.
- `rst` = 0 in the middle of word 3, then a fresh `start` and a valid frame → all outputs 0 during reset, `cpu_run` = 0 throughout the aborted load, and the fresh frame completes normally.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the boot-time program loader.
//               Holds the loader state encoding, instruction memory depth and
//               the derived address / length-counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Instruction memory depth in 32-bit words.
  localparam int MAX_WORDS  = 256;
  // Word address width into the instruction memory.
  localparam int ADDR_WIDTH = 8;
  // Counter width able to hold 0..MAX_WORDS inclusive.
  localparam int LEN_WIDTH  = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loaderState_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Byte-stream input and instruction-memory write port of the
//               program loader, bundled as one interface.
//   in_data/in_valid/in_ready : framed byte stream (transfer = valid & ready)
//   imem_we/imem_addr/imem_wdata : instruction memory write port
//   modport slave  : the loader (stream sink, memory writer)
//   modport master : the stream source / memory observer
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if;
  import loader_pkg::*;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/word_packer.sv
`default_nettype none
// ============================================================================
// Module      : word_packer
// Description : Packs accepted stream bytes MSB-first into 32-bit words.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : restart packing at byte 0 (new load)
//   byteValid     : a payload byte is accepted this cycle
//   byteIn        : the payload byte
//   lastByte      : combinational, this accepted byte completes a word
//   wordValid     : registered one-cycle pulse, word is complete
//   word          : assembled word (first byte in bits 31:24)
// Revision    : 1.0 - initial release
// ============================================================================
module word_packer (
  input  wire         clk,
  input  wire         rst,
  input  wire         clear,
  input  wire         byteValid,
  input  wire  [7:0]  byteIn,
  output logic        lastByte,
  output logic        wordValid,
  output logic [31:0] word
);

  logic [1:0]  r_byteCnt;
  logic [31:0] r_shift;
  logic        r_wordValid;

  assign lastByte  = byteValid & (r_byteCnt == 2'd3);
  assign wordValid = r_wordValid;
  assign word      = r_shift;

  // Shifting left means the first byte ends up in bits 31:24 after four
  // bytes; the register then holds the word during the wordValid cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byteCnt   <= 2'd0;
      r_shift     <= 32'd0;
      r_wordValid <= 1'b0;
    end else if (clear) begin
      r_byteCnt   <= 2'd0;
      r_shift     <= 32'd0;
      r_wordValid <= 1'b0;
    end else begin
      r_wordValid <= lastByte;
      if (byteValid) begin
        r_shift   <= {r_shift[23:0], byteIn};
        r_byteCnt <= r_byteCnt + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot-time program loader. Receives a framed byte stream
//               (16-bit big-endian word count, big-endian words, XOR
//               checksum of the payload bytes), writes each word into the
//               instruction memory and releases the processor only after a
//               frame with a matching checksum.
//   clk      : single system clock
//   rst      : asynchronous active-low reset
//   start    : one-cycle pulse beginning a load (ignored while busy)
//   bus      : byte stream in, instruction memory write port out
//   cpu_run  : releases the processor (processor reset = rst & cpu_run)
//   busy     : a load is in progress
//   err      : the last load failed on length or checksum
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import loader_pkg::*;
(
  input  wire         clk,
  input  wire         rst,
  input  wire         start,
  prog_loader_if.slave bus,
  output logic        cpu_run,
  output logic        busy,
  output logic        err
);

  loaderState_t r_state;
  loaderState_t w_stateNext;

  logic [7:0]            r_lenHi;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_wcnt;
  logic [LEN_WIDTH-1:0]  w_wcntInc;
  logic [7:0]            r_xsum;
  logic [ADDR_WIDTH-1:0] r_imemAddr;
  logic                  r_cpuRun;
  logic                  r_err;

  logic        w_busy;
  logic        w_xfer;
  logic        w_startAccept;
  logic        w_packEn;
  logic        w_lastByte;
  logic        w_wordValid;
  logic [15:0] w_lenFull;
  logic [31:0] w_word;

  assign w_busy = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                  (r_state == DATA)   || (r_state == CSUM);
  // Bytes outside the busy states are never consumed.
  assign w_xfer        = bus.in_valid & w_busy;
  assign w_startAccept = start & ~w_busy;
  assign w_lenFull     = {r_lenHi, bus.in_data};
  assign w_packEn      = w_xfer & (r_state == DATA);
  assign w_wcntInc     = r_wcnt + 1'b1;

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_startAccept),
    .byteValid (w_packEn),
    .byteIn    (bus.in_data),
    .lastByte  (w_lastByte),
    .wordValid (w_wordValid),
    .word      (w_word)
  );

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (w_startAccept) w_stateNext = LEN_HI;
      end
      LEN_HI: begin
        if (w_xfer) w_stateNext = LEN_LO;
      end
      LEN_LO: begin
        if (w_xfer) begin
          if (w_lenFull > 16'(MAX_WORDS)) w_stateNext = ERR;
          else if (w_lenFull == 16'd0)    w_stateNext = CSUM;
          else                            w_stateNext = DATA;
        end
      end
      DATA: begin
        // The word being completed now is word wcnt; it is the last one
        // when wcnt+1 reaches the frame length.
        if (w_lastByte && (w_wcntInc == r_len)) w_stateNext = CSUM;
      end
      CSUM: begin
        if (w_xfer) w_stateNext = (bus.in_data == r_xsum) ? DONE : ERR;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_lenHi    <= 8'd0;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_xsum     <= 8'd0;
      r_imemAddr <= '0;
      r_cpuRun   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      // Flags follow the next state so they rise the cycle after the
      // deciding transfer and drop the cycle after an accepted start.
      r_cpuRun <= (w_stateNext == DONE);
      r_err    <= (w_stateNext == ERR);

      if (w_startAccept) begin
        r_wcnt <= '0;
        r_xsum <= 8'd0;
      end else begin
        if (w_packEn) r_xsum <= r_xsum ^ bus.in_data;
        if (w_lastByte) begin
          r_imemAddr <= r_wcnt[ADDR_WIDTH-1:0];
          r_wcnt     <= w_wcntInc;
        end
      end

      if (w_xfer && (r_state == LEN_HI)) r_lenHi <= bus.in_data;
      if (w_xfer && (r_state == LEN_LO)) r_len   <= w_lenFull[LEN_WIDTH-1:0];
    end
  end

  assign bus.in_ready   = w_busy;
  assign bus.imem_we    = w_wordValid;
  assign bus.imem_addr  = r_imemAddr;
  assign bus.imem_wdata = w_word;
  assign busy           = w_busy;
  assign cpu_run        = r_cpuRun;
  assign err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader: table of whole frames
//               plus hand-written sequences for start-while-busy, stalls,
//               a full 256-word frame and reset in the middle of a load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  import loader_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic cpu_run, busy, err;

  prog_loader_if ifc ();

  prog_loader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (ifc),
    .cpu_run (cpu_run),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Write log, owned by the monitor; the stimulus asks for a clear.
  int          wrCnt  [MAX_WORDS];
  logic [31:0] wrData [MAX_WORDS];
  int          wrTotal  = 0;
  int          lastAddr = -1;
  bit          clearLog = 1'b0;
  bit          watchRun = 1'b0;
  bit          runSeen  = 1'b0;

  always @(negedge clk) begin
    if (clearLog) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        wrCnt[i]  = 0;
        wrData[i] = 32'd0;
      end
      wrTotal  = 0;
      lastAddr = -1;
      runSeen  = 1'b0;
    end else begin
      if (ifc.imem_we) begin
        wrCnt[ifc.imem_addr]  = wrCnt[ifc.imem_addr] + 1;
        wrData[ifc.imem_addr] = ifc.imem_wdata;
        wrTotal  = wrTotal + 1;
        lastAddr = int'(ifc.imem_addr);
      end
      if (watchRun && cpu_run) runSeen = 1'b1;
    end
  end

  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csum;
    bit          expErr;
    bit          expRun;
    int          expWrites;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doClearLog();
    clearLog = 1'b1;
    tick();
    clearLog = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a byte after 'gap' idle cycles and hold it until accepted.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int n;
    ifc.in_valid = 1'b0;
    repeat (gap) tick();
    ifc.in_data  = b;
    ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ifc.in_ready) begin
      nCompared++;
      nMismatched++;
      $display("FAIL byte_accept_timeout: in_ready stayed %b, required 1", ifc.in_ready);
    end
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    sendByte(w[31:24], gap);
    sendByte(w[23:16], gap);
    sendByte(w[15:8],  gap);
    sendByte(w[7:0],   gap);
  endtask

  function automatic logic [31:0] bigWord(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A, 8'(i * 7)};
  endfunction

  task automatic checkAllZero(input string tag);
    check({tag, "_in_ready"},   ifc.in_ready,   1'b0);
    check({tag, "_imem_we"},    ifc.imem_we,    1'b0);
    check({tag, "_imem_addr"},  ifc.imem_addr,  8'd0);
    check({tag, "_imem_wdata"}, ifc.imem_wdata, 32'd0);
    check({tag, "_busy"},       busy,           1'b0);
    check({tag, "_err"},        err,            1'b0);
    check({tag, "_cpu_run"},    cpu_run,        1'b0);
  endtask

  initial begin
    logic [7:0]  xs;
    logic [31:0] w;
    int          bad;

    ifc.in_data  = 8'd0;
    ifc.in_valid = 1'b0;

    vecs[0] = '{16'd2,      32'h20010005, 32'h8C220000, 8'h8A, 1'b0, 1'b1, 2};
    vecs[1] = '{16'd2,      32'h20010005, 32'h8C220000, 8'h8B, 1'b1, 1'b0, 2};
    vecs[2] = '{16'h0101,   32'h0,        32'h0,        8'h00, 1'b1, 1'b0, 0};
    vecs[3] = '{16'd0,      32'h0,        32'h0,        8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{16'd1,      32'hDEADBEEF, 32'h0,        8'h22, 1'b0, 1'b1, 1};
    vecs[5] = '{16'd0,      32'h0,        32'h0,        8'h5A, 1'b1, 1'b0, 0};
    vecs[6] = '{16'h8000,   32'h0,        32'h0,        8'h00, 1'b1, 1'b0, 0};

    // Reset state.
    #12;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Table-driven frames, each starting from the previous end state.
    for (int v = 0; v < NV; v++) begin
      doClearLog();
      pulseStart();
      check($sformatf("v%0d_start_ready", v), ifc.in_ready, 1'b1);
      check($sformatf("v%0d_start_run", v),   cpu_run,      1'b0);
      check($sformatf("v%0d_start_err", v),   err,          1'b0);
      sendByte(vecs[v].len[15:8], 0);
      sendByte(vecs[v].len[7:0],  0);
      if (vecs[v].len > 16'(MAX_WORDS)) begin
        check($sformatf("v%0d_len_ready", v), ifc.in_ready, 1'b0);
        check($sformatf("v%0d_len_busy", v),  busy,         1'b0);
        tick();
      end else begin
        if (vecs[v].len >= 16'd1) sendWord(vecs[v].w0, 0);
        if (vecs[v].len >= 16'd2) sendWord(vecs[v].w1, 0);
        sendByte(vecs[v].csum, 0);
        check($sformatf("v%0d_busy", v), busy, 1'b0);
      end
      check($sformatf("v%0d_err", v),     err,     vecs[v].expErr);
      check($sformatf("v%0d_cpu_run", v), cpu_run, vecs[v].expRun);
      check($sformatf("v%0d_writes", v),  wrTotal, vecs[v].expWrites);
      if (vecs[v].expWrites >= 1) begin
        check($sformatf("v%0d_w0", v),    wrData[0], vecs[v].w0);
        check($sformatf("v%0d_w0cnt", v), wrCnt[0],  1);
      end
      if (vecs[v].expWrites >= 2) begin
        check($sformatf("v%0d_w1", v),    wrData[1], vecs[v].w1);
        check($sformatf("v%0d_w1cnt", v), wrCnt[1],  1);
      end
    end

    // Start pulse in the middle of a load must be ignored.
    doClearLog();
    pulseStart();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    pulseStart();
    check("midstart_busy", busy, 1'b1);
    sendWord(32'hCAFEF00D, 1);
    sendByte(8'hC9, 0);
    check("midstart_run",  cpu_run,   1'b1);
    check("midstart_err",  err,       1'b0);
    check("midstart_word", wrData[0], 32'hCAFEF00D);

    // Stream bytes while DONE are not taken.
    ifc.in_data  = 8'h77;
    ifc.in_valid = 1'b1;
    repeat (3) tick();
    check("done_ready", ifc.in_ready, 1'b0);
    check("done_run",   cpu_run,      1'b1);
    ifc.in_valid = 1'b0;

    // Full-depth frame with random stalls.
    doClearLog();
    pulseStart();
    sendByte(8'h01, $urandom_range(0, 2));
    sendByte(8'h00, $urandom_range(0, 2));
    xs = 8'd0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      w  = bigWord(i);
      xs = xs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      sendWord(w, $urandom_range(0, 2));
    end
    sendByte(xs, $urandom_range(0, 2));
    check("full_run",    cpu_run,  1'b1);
    check("full_err",    err,      1'b0);
    check("full_writes", wrTotal,  MAX_WORDS);
    check("full_last",   lastAddr, 255);
    bad = 0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (wrCnt[i] != 1 || wrData[i] !== bigWord(i)) bad++;
    end
    check("full_bad_addrs", bad, 0);

    // Reset in the middle of word index 2 of a three-word frame.
    doClearLog();
    pulseStart();
    watchRun = 1'b1;
    sendByte(8'h00, 0);
    sendByte(8'h03, 0);
    sendWord(32'h11223344, 0);
    sendWord(32'h55667788, 0);
    sendByte(8'h99, 0);
    sendByte(8'hAA, 0);
    rst = 1'b0;
    #2;
    checkAllZero("midrst");
    tick();
    tick();
    watchRun = 1'b0;
    check("midrst_run_seen", runSeen, 1'b0);
    check("midrst_writes",   wrTotal, 2);
    rst = 1'b1;
    tick();

    doClearLog();
    pulseStart();
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    sendWord(32'h20010005, 0);
    sendWord(32'h8C220000, 0);
    sendByte(8'h8A, 0);
    check("fresh_run",    cpu_run,   1'b1);
    check("fresh_err",    err,       1'b0);
    check("fresh_writes", wrTotal,   2);
    check("fresh_w0",     wrData[0], 32'h20010005);
    check("fresh_w1",     wrData[1], 32'h8C220000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
